// File: rtl/rx_engine.sv
// ---------------------------------------------------------------------------
// RxEngine -- UART receive engine
//
// Purpose:
//   Receives asynchronous serial characters from the rx pin. The line is
//   synchronized, a falling edge starts a frame, and the start bit is
//   confirmed at mid-bit. Data bits (7 or 8, LSB first), an optional parity
//   bit and the stop bit are then sampled once per bit period. One cycle
//   after the stop-bit sample the character and its status flags are
//   published together. The status flags stay set until the read strobe.
//
// Parameters:
//   CLK_HZ     system clock frequency in Hz; the bit periods are derived from it
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   rx         serial input, idle high, asynchronous to clk
//   rd         one-cycle read strobe; clears rxrdy/perr/ferr/ovf
//   baud_mode  baud select (0..11 = 300 .. 921600, 12..15 = 921600)
//   bit8       1 = 8 data bits, 0 = 7 data bits
//   pen        1 = parity bit present
//   ohel       parity sense, 1 = odd, 0 = even
//   rx_data    last received character (bit 7 is 0 in 7-bit mode)
//   rxrdy      character available, held until rd
//   perr       parity error of the last character
//   ferr       framing error (stop bit was 0) of the last character
//   ovf        a character was overwritten before it was read
//
// Configuration:
//   RX_MAJORITY_EN  when defined, each bit sample is the 2-of-3 majority of
//                   the synchronized line at count expiry and the two clocks
//                   before it; otherwise a single sample is taken at expiry.
// ---------------------------------------------------------------------------
module rx_engine #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  input  logic [3:0] baud_mode,
  input  logic       bit8,
  input  logic       pen,
  input  logic       ohel,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  // Wide enough to hold the slowest (300 baud) bit period without wrapping.
  localparam int CW = $clog2(CLK_HZ / 300 + 1);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t BT_300    = cnt_t'(CLK_HZ / 300);
  localparam cnt_t BT_1200   = cnt_t'(CLK_HZ / 1200);
  localparam cnt_t BT_2400   = cnt_t'(CLK_HZ / 2400);
  localparam cnt_t BT_4800   = cnt_t'(CLK_HZ / 4800);
  localparam cnt_t BT_9600   = cnt_t'(CLK_HZ / 9600);
  localparam cnt_t BT_19200  = cnt_t'(CLK_HZ / 19200);
  localparam cnt_t BT_38400  = cnt_t'(CLK_HZ / 38400);
  localparam cnt_t BT_57600  = cnt_t'(CLK_HZ / 57600);
  localparam cnt_t BT_115200 = cnt_t'(CLK_HZ / 115200);
  localparam cnt_t BT_230400 = cnt_t'(CLK_HZ / 230400);
  localparam cnt_t BT_460800 = cnt_t'(CLK_HZ / 460800);
  localparam cnt_t BT_921600 = cnt_t'(CLK_HZ / 921600);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state;
  state_t     state_n;
  cnt_t       cnt;
  cnt_t       cnt_n;
  cnt_t       bt;
  cnt_t       half_bt;
  logic       expiry;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_n;
  logic [2:0] last_bit;

  logic       sync1;
  logic       sync2;
  logic       smp;

  logic       clr_acc;
  logic       shift_en;
  logic       par_en;
  logic       stop_en;

  logic [7:0] shreg;
  logic       par_acc;
  logic       frame_done;
  logic       perr_pend;
  logic       ferr_pend;

  // Two-flop synchronizer; flops come out of reset at the idle level so a
  // reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

`ifdef RX_MAJORITY_EN
  logic hist1;
  logic hist2;

  // History of the synchronized line for the 2-of-3 vote: hist1 is one clock
  // old, hist2 two clocks old.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist1 <= 1'b1;
      hist2 <= 1'b1;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
    end
  end

  assign smp = (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
`else
  assign smp = sync2;
`endif

  // Bit period for the selected baud rate; all codes above 11 alias the
  // fastest rate.
  always_comb begin
    bt = BT_921600;
    case (baud_mode)
      4'd0:    bt = BT_300;
      4'd1:    bt = BT_1200;
      4'd2:    bt = BT_2400;
      4'd3:    bt = BT_4800;
      4'd4:    bt = BT_9600;
      4'd5:    bt = BT_19200;
      4'd6:    bt = BT_38400;
      4'd7:    bt = BT_57600;
      4'd8:    bt = BT_115200;
      4'd9:    bt = BT_230400;
      4'd10:   bt = BT_460800;
      default: bt = BT_921600;
    endcase
  end

  assign half_bt  = bt >> 1;
  // A loaded value N expires exactly N clocks later (the edge on which the
  // counter reads 1); a zero count is treated as already expired.
  assign expiry   = (cnt <= cnt_t'(1));
  assign last_bit = bit8 ? 3'd7 : 3'd6;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
    end
  end

  // Next-state logic. The counter free-runs down and is reloaded on every
  // sample point, so each bit is timed from the previous sample.
  always_comb begin
    state_n   = state;
    cnt_n     = (cnt != '0) ? cnt - cnt_t'(1) : '0;
    bit_cnt_n = bit_cnt;
    clr_acc   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    case (state)
      IDLE: begin
        if (!sync2) begin
          state_n = START;
          cnt_n   = half_bt;
          clr_acc = 1'b1;
        end
      end
      START: begin
        if (expiry) begin
          if (!smp) begin
            state_n   = DATA;
            cnt_n     = bt;
            bit_cnt_n = '0;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end
      DATA: begin
        if (expiry) begin
          shift_en = 1'b1;
          cnt_n    = bt;
          if (bit_cnt == last_bit) begin
            state_n = pen ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (expiry) begin
          par_en  = 1'b1;
          cnt_n   = bt;
          state_n = STOP;
        end
      end
      STOP: begin
        if (expiry) begin
          stop_en = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Frame assembly. Data shifts in from the top so that after 7 bits the
  // character sits in shreg[7:1]. par_acc accumulates the XOR of all data
  // bits plus the parity bit. The stop sample latches pending flags that
  // are published one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg      <= '0;
      par_acc    <= 1'b0;
      frame_done <= 1'b0;
      perr_pend  <= 1'b0;
      ferr_pend  <= 1'b0;
    end else begin
      frame_done <= stop_en;
      if (clr_acc) begin
        shreg   <= '0;
        par_acc <= 1'b0;
      end else if (shift_en) begin
        shreg   <= {smp, shreg[7:1]};
        par_acc <= par_acc ^ smp;
      end else if (par_en) begin
        par_acc <= par_acc ^ smp;
      end
      if (stop_en) begin
        ferr_pend <= ~smp;
        perr_pend <= pen & (par_acc ^ ohel);
      end
    end
  end

  // Processor-visible status. A completing frame takes priority over a
  // coincident read; a read on that same cycle still suppresses overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_data <= 8'h00;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (frame_done) begin
      rx_data <= bit8 ? shreg : {1'b0, shreg[7:1]};
      rxrdy   <= 1'b1;
      perr    <= perr_pend;
      ferr    <= ferr_pend;
      ovf     <= rxrdy & ~rd;
    end else if (rd) begin
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_engine.sv
// ---------------------------------------------------------------------------
// tb_rx_engine -- directed, table-driven testbench for rx_engine
//
// The engine is built with a small CLK_HZ so bit periods are short:
// baud_mode 8 -> 10 clocks, 9 -> 5 clocks, 4 -> 120 clocks.
// ---------------------------------------------------------------------------
module tb_rx_engine;

  localparam int CLK_HZ = 1_152_000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [3:0] baud_mode = 4'd8;
  logic       bit8 = 1'b1;
  logic       pen = 1'b0;
  logic       ohel = 1'b0;
  logic [7:0] rx_data;
  logic       rxrdy;
  logic       perr;
  logic       ferr;
  logic       ovf;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] mode;
    logic       b8;
    logic       pe;
    logic       oh;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  rx_engine #(.CLK_HZ(CLK_HZ)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd        (rd),
    .baud_mode (baud_mode),
    .bit8      (bit8),
    .pen       (pen),
    .ohel      (ohel),
    .rx_data   (rx_data),
    .rxrdy     (rxrdy),
    .perr      (perr),
    .ferr      (ferr),
    .ovf       (ovf)
  );

  // 100 MHz simulation clock.
  always #5 clk = ~clk;

  // Safety net in case the engine never settles.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int btOf(input logic [3:0] m);
    case (m)
      4'd0:    return CLK_HZ / 300;
      4'd1:    return CLK_HZ / 1200;
      4'd2:    return CLK_HZ / 2400;
      4'd3:    return CLK_HZ / 4800;
      4'd4:    return CLK_HZ / 9600;
      4'd5:    return CLK_HZ / 19200;
      4'd6:    return CLK_HZ / 38400;
      4'd7:    return CLK_HZ / 57600;
      4'd8:    return CLK_HZ / 115200;
      4'd9:    return CLK_HZ / 230400;
      4'd10:   return CLK_HZ / 460800;
      default: return CLK_HZ / 921600;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold the line at a level for n clocks; always returns 1 time unit after
  // a rising edge.
  task automatic driveLevel(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A frame with a 0 stop bit holds the line low only a little past mid-bit,
  // so any start the engine sees afterwards is rejected as a false start.
  task automatic sendFrame(input logic [7:0] d, input int nbits, input logic has_par,
                           input logic par_bit, input logic stop_bit, input int bt);
    logic [7:0] dv;
    dv = d;
    driveLevel(1'b0, bt);
    for (int i = 0; i < nbits; i++) driveLevel(dv[i], bt);
    if (has_par) driveLevel(par_bit, bt);
    if (stop_bit) begin
      driveLevel(1'b1, bt);
    end else begin
      driveLevel(1'b0, bt / 2 + 4);
      driveLevel(1'b1, bt - bt / 2 - 4);
    end
    rx = 1'b1;
  endtask

  task automatic waitRxrdy(input int budget, output logic seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (rxrdy) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulseRd();
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int   bt;
    int   nbits;
    int   budget;
    logic seen;
    baud_mode = v.mode;
    bit8      = v.b8;
    pen       = v.pe;
    ohel      = v.oh;
    bt        = btOf(v.mode);
    nbits     = v.b8 ? 8 : 7;
    budget    = (2 + nbits + (v.pe ? 1 : 0)) * bt + 3;
    fork
      sendFrame(v.data, nbits, v.pe, v.par_bit, v.stop_bit, bt);
      waitRxrdy(budget, seen);
    join
    driveLevel(1'b1, 2 * bt);
    checkOutput($sformatf("v%0d_rxrdy_in_time", idx), seen, 1);
    checkOutput($sformatf("v%0d_rxrdy", idx), rxrdy, 1);
    checkOutput($sformatf("v%0d_data", idx), rx_data, v.exp_data);
    checkOutput($sformatf("v%0d_perr", idx), perr, v.exp_perr);
    checkOutput($sformatf("v%0d_ferr", idx), ferr, v.exp_ferr);
    checkOutput($sformatf("v%0d_ovf", idx), ovf, 0);
    pulseRd();
    checkOutput($sformatf("v%0d_rd_rxrdy", idx), rxrdy, 0);
    checkOutput($sformatf("v%0d_rd_flags", idx), {perr, ferr, ovf}, 0);
    checkOutput($sformatf("v%0d_rd_hold", idx), rx_data, v.exp_data);
  endtask

  initial begin
    logic seen;
    int   bt;

    //          mode  b8    pe    oh    data   par   stop  exp    perr  ferr
    vecs[0] = '{4'd8, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[1] = '{4'd8, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{4'd4, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1};
    vecs[3] = '{4'd8, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
    vecs[4] = '{4'd8, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[5] = '{4'd8, 1'b0, 1'b0, 1'b0, 8'hD5, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[6] = '{4'd9, 1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[7] = '{4'd8, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_data", rx_data, 8'h00);
    checkOutput("reset_status", {rxrdy, perr, ferr, ovf}, 0);
    reset = 1'b1;
    driveLevel(1'b1, 5);

    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

    // Framing error, then a short low glitch on the idle line.
    baud_mode = 4'd4;
    bit8 = 1'b1;
    pen = 1'b0;
    ohel = 1'b0;
    bt = btOf(4'd4);
    fork
      sendFrame(8'h33, 8, 1'b0, 1'b0, 1'b0, bt);
      waitRxrdy(10 * bt + 3, seen);
    join
    driveLevel(1'b1, 2 * bt);
    checkOutput("glitch_pre_ferr", {rxrdy, ferr}, 2'b11);
    driveLevel(1'b0, 20);
    driveLevel(1'b1, 2 * bt);
    checkOutput("glitch_rxrdy", rxrdy, 1);
    checkOutput("glitch_data", rx_data, 8'h33);
    checkOutput("glitch_flags", {perr, ferr, ovf}, 3'b010);
    pulseRd();

    // Back-to-back frames without a read: overrun.
    baud_mode = 4'd8;
    bt = btOf(4'd8);
    fork
      begin
        sendFrame(8'h11, 8, 1'b0, 1'b0, 1'b1, bt);
        sendFrame(8'h22, 8, 1'b0, 1'b0, 1'b1, bt);
      end
      waitRxrdy(10 * bt + 3, seen);
    join
    driveLevel(1'b1, 2 * bt);
    checkOutput("ovf_first_seen", seen, 1);
    checkOutput("ovf_data", rx_data, 8'h22);
    checkOutput("ovf_set", {rxrdy, ovf}, 2'b11);
    pulseRd();
    checkOutput("ovf_rd_clear", {rxrdy, ovf}, 0);

    // Same again, with rd on the second frame's completion cycle. The second
    // frame starts exactly 10 bit times after the first, so it completes
    // exactly 10 bit times after the first one did.
    fork
      begin
        sendFrame(8'h11, 8, 1'b0, 1'b0, 1'b1, bt);
        sendFrame(8'h22, 8, 1'b0, 1'b0, 1'b1, bt);
      end
      begin
        waitRxrdy(10 * bt + 3, seen);
        repeat (10 * bt - 1) @(posedge clk);
        #1;
        pulseRd();
      end
    join
    driveLevel(1'b1, 2 * bt);
    checkOutput("rdwin_data", rx_data, 8'h22);
    checkOutput("rdwin_rxrdy", rxrdy, 1);
    checkOutput("rdwin_ovf", ovf, 0);

    // Reset in the middle of a frame (status still holds 0x22 from above).
    bit8 = 1'b0;
    pen = 1'b1;
    ohel = 1'b1;
    driveLevel(1'b0, bt);
    driveLevel(1'b1, bt);
    driveLevel(1'b0, bt);
    driveLevel(1'b1, bt / 2);
    reset = 1'b0;
    rx = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_data", rx_data, 8'h00);
    checkOutput("midreset_status", {rxrdy, perr, ferr, ovf}, 0);
    reset = 1'b1;
    driveLevel(1'b1, 12 * bt);
    checkOutput("midreset_no_partial", rxrdy, 0);
    fork
      sendFrame(8'h2A, 7, 1'b1, 1'b0, 1'b1, bt);
      waitRxrdy(10 * bt + 3, seen);
    join
    driveLevel(1'b1, 2 * bt);
    checkOutput("postreset_seen", seen, 1);
    checkOutput("postreset_data", rx_data, 8'h2A);
    checkOutput("postreset_flags", {perr, ferr, ovf}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
